// File: rtl/sym_vn_lut_loader_if.sv
// Load-command, entry-stream and LUT write-port signals of the symmetric VN rank LUT loader.
// The loader is the slave: it receives commands and entries and drives the write port.
interface sym_vn_lut_loader_if #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W-1:0] load_len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] lut_in_bank0_replicate_0;
  logic [ADDR_W-1:0] page_write_addr_replicate_0;
  logic [DATA_W-1:0] lut_in_bank0_replicate_1;
  logic [ADDR_W-1:0] page_write_addr_replicate_1;
  logic              we;
  logic              busy;
  logic              load_done;

  modport master (
    output load_start, load_base, load_len, in_data, in_valid,
    input  in_ready,
    input  lut_in_bank0_replicate_0, page_write_addr_replicate_0,
    input  lut_in_bank0_replicate_1, page_write_addr_replicate_1,
    input  we, busy, load_done
  );

  modport slave (
    input  load_start, load_base, load_len, in_data, in_valid,
    output in_ready,
    output lut_in_bank0_replicate_0, page_write_addr_replicate_0,
    output lut_in_bank0_replicate_1, page_write_addr_replicate_1,
    output we, busy, load_done
  );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// Streams 3-bit entries into both replicates of the symmetric VN rank LUT with registered
// write outputs, so the two VNU read ports always see identical tables.
module sym_vn_lut_loader #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                 write_clk,
  input  logic                 rstn,
  sym_vn_lut_loader_if.slave   lb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int REM_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [REM_W-1:0]  rem_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              we_q;
  logic              done_q;
  logic              accept;
  logic              start_ok;

  assign accept   = (state_q == LOAD) && lb.in_valid;
  assign start_ok = (state_q == IDLE) && lb.load_start;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (lb.load_start) state_d = LOAD;
      LOAD:    if (accept && (rem_q == REM_W'(1))) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write data and address are only updated on an accepted beat; we alone marks validity.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      rem_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      we_q   <= accept;
      done_q <= (state_q == FLUSH);
      if (start_ok) begin
        addr_q <= lb.load_base;
        rem_q  <= (lb.load_len == '0) ? REM_W'(DEPTH) : {1'b0, lb.load_len};
      end else if (accept) begin
        addr_q    <= addr_q + ADDR_W'(1);
        rem_q     <= rem_q - REM_W'(1);
        wr_data_q <= lb.in_data;
        wr_addr_q <= addr_q;
      end
    end
  end

  assign lb.in_ready                    = (state_q == LOAD);
  assign lb.busy                        = (state_q != IDLE);
  assign lb.we                          = we_q;
  assign lb.load_done                   = done_q;
  assign lb.lut_in_bank0_replicate_0    = wr_data_q;
  assign lb.lut_in_bank0_replicate_1    = wr_data_q;
  assign lb.page_write_addr_replicate_0 = wr_addr_q;
  assign lb.page_write_addr_replicate_1 = wr_addr_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Scoreboard bench for sym_vn_lut_loader: accepted beats queue their expected write,
// a negedge monitor pops and compares every we cycle.
module tb_sym_vn_lut_loader;
  localparam int DATA_W = 3;
  localparam int ADDR_W = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sym_vn_lut_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) lb ();

  sym_vn_lut_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32)) dut (
    .write_clk (clk),
    .rstn      (rstn),
    .lb        (lb)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [ADDR_W-1:0] model_addr = '0;

  int we_count, busy_count, done_count, first_we_cyc, last_we_cyc, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clear_stats();
    we_count = 0; busy_count = 0; done_count = 0;
    first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1;
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (lb.busy) busy_count++;
      if (lb.load_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (lb.we) begin
        if (we_count == 0) first_we_cyc = cyc;
        we_count++;
        last_we_cyc = cyc;
        check("rep_data_equal", int'(lb.lut_in_bank0_replicate_1), int'(lb.lut_in_bank0_replicate_0));
        check("rep_addr_equal", int'(lb.page_write_addr_replicate_1), int'(lb.page_write_addr_replicate_0));
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_we: addr=%0d data=%0d with empty scoreboard (t=%0t)",
                   lb.page_write_addr_replicate_0, lb.lut_in_bank0_replicate_0, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_addr", int'(lb.page_write_addr_replicate_0), int'(e.addr));
          check("wr_data", int'(lb.lut_in_bank0_replicate_0), int'(e.data));
          check("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One cycle of stream stimulus; an accepted beat queues its write for the next cycle.
  task automatic drive_beat(input logic v, input logic [DATA_W-1:0] d);
    exp_t e;
    lb.in_valid = v;
    lb.in_data  = d;
    if (v && lb.in_ready) begin
      e.addr = model_addr;
      e.data = d;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      model_addr = model_addr + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, '0);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    lb.load_start = 1'b1;
    lb.load_base  = base;
    lb.load_len   = len;
    model_addr    = base;
    @(posedge clk); #1;
    lb.load_start = 1'b0;
    check("in_ready_after_start", int'(lb.in_ready), 1);
  endtask

  initial begin
    int found;
    int len;
    int accepted;
    lb.load_start = 1'b0;
    lb.load_base  = '0;
    lb.load_len   = '0;
    lb.in_data    = '0;
    lb.in_valid   = 1'b0;
    clear_stats();

    // Reset state
    #12;
    check("rst_we", int'(lb.we), 0);
    check("rst_in_ready", int'(lb.in_ready), 0);
    check("rst_busy", int'(lb.busy), 0);
    check("rst_load_done", int'(lb.load_done), 0);
    check("rst_data", int'(lb.lut_in_bank0_replicate_0), 0);
    check("rst_addr", int'(lb.page_write_addr_replicate_0), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);

    // Full load: len=0 encodes 32, data i%8 back-to-back
    clear_stats();
    start_load(5'd0, 5'd0);
    for (int i = 0; i < 32; i++) drive_beat(1'b1, DATA_W'(i % 8));
    idle(4);
    check("full_we_count", we_count, 32);
    check("full_we_span", last_we_cyc - first_we_cyc, 31);
    check("full_busy_cycles", busy_count, 33);
    check("full_done_count", done_count, 1);
    check("full_done_timing", done_cyc, last_we_cyc + 1);

    // Wrap-around 30,31,0,1; valid stays high into FLUSH/IDLE and must be ignored
    clear_stats();
    start_load(5'd30, 5'd4);
    drive_beat(1'b1, 3'd5);
    drive_beat(1'b1, 3'd6);
    drive_beat(1'b1, 3'd7);
    drive_beat(1'b1, 3'd1);
    check("wrap_in_ready_flush", int'(lb.in_ready), 0);
    drive_beat(1'b1, 3'd2);
    drive_beat(1'b1, 3'd2);
    idle(3);
    check("wrap_we_count", we_count, 4);
    check("wrap_done_count", done_count, 1);
    check("wrap_done_timing", done_cyc, last_we_cyc + 1);

    // Stalls: valid pattern 1,0,0,1,0,1
    clear_stats();
    start_load(5'd12, 5'd3);
    drive_beat(1'b1, 3'd4);
    drive_beat(1'b0, 3'd0);
    drive_beat(1'b0, 3'd0);
    drive_beat(1'b1, 3'd2);
    drive_beat(1'b0, 3'd0);
    drive_beat(1'b1, 3'd6);
    idle(3);
    check("stall_we_count", we_count, 3);
    check("stall_done_count", done_count, 1);

    // load_start mid-load is ignored; load_start with load_done starts a new load
    clear_stats();
    start_load(5'd10, 5'd6);
    drive_beat(1'b1, 3'd1);
    drive_beat(1'b1, 3'd2);
    lb.load_start = 1'b1;
    lb.load_base  = 5'd7;
    lb.load_len   = 5'd3;
    drive_beat(1'b1, 3'd3);
    lb.load_start = 1'b0;
    drive_beat(1'b1, 3'd4);
    drive_beat(1'b1, 3'd5);
    drive_beat(1'b1, 3'd6);
    lb.in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (lb.load_done) begin
        found = 1;
        break;
      end
      drive_beat(1'b0, '0);
    end
    check("load_done_seen", found, 1);
    if (found == 1) begin
      start_load(5'd20, 5'd2);
      drive_beat(1'b1, 3'd7);
      drive_beat(1'b1, 3'd0);
    end
    idle(3);
    check("restart_we_count", we_count, 8);
    check("restart_done_count", done_count, 2);

    // Reset after 10 of 32 beats
    clear_stats();
    start_load(5'd0, 5'd0);
    for (int i = 0; i < 10; i++) drive_beat(1'b1, DATA_W'(i + 1));
    rstn = 1'b0;
    #1;
    check("midrst_we", int'(lb.we), 0);
    check("midrst_busy", int'(lb.busy), 0);
    check("midrst_in_ready", int'(lb.in_ready), 0);
    sb.delete();
    lb.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(3);
    check("midrst_we_count", we_count, 9);
    check("midrst_no_done", done_count, 0);
    clear_stats();
    start_load(5'd0, 5'd1);
    drive_beat(1'b1, 3'd3);
    idle(3);
    check("postrst_we_count", we_count, 1);
    check("postrst_done_count", done_count, 1);

    // Random load with random stalls
    clear_stats();
    len = $urandom_range(1, 8);
    start_load(ADDR_W'($urandom_range(0, 31)), ADDR_W'(len));
    accepted = 0;
    for (int i = 0; i < 100 && accepted < len; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if (v && lb.in_ready) accepted++;
      drive_beat(v, DATA_W'($urandom_range(0, 7)));
    end
    idle(3);
    check("rand_accepted", accepted, len);
    check("rand_we_count", we_count, len);
    check("rand_done_count", done_count, 1);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_loader.md
Name: sym_vn_lut_loader

Overview:
- Write-side producer for the symmetric VN rank LUT: accepts a valid/ready stream of 3-bit LUT entries and drives the LUT write port set (two replicate data/address pairs plus one write enable).
- Both replicates receive identical data at identical addresses in the same cycle, so the two VNU read ports always see coherent tables.
- Sits between the IB-LUT reconfiguration source (per-iteration table update) and the LUT bank. Flags busy so the decoder schedule holds VNU reads during reload.

Parameters:
- DATA_W, 3, LUT entry width.
- ADDR_W, 5, page address width.
- DEPTH, 32, table depth; equals 2^ADDR_W.

Ports:
- write_clk  input  1  clock, shared with the LUT write port.
- rstn  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- load_base  input  ADDR_W  first page address written; captured with load_start.
- load_len  input  ADDR_W  entry count; 0 encodes DEPTH (32); captured with load_start.
- in_data  input  DATA_W  stream entry.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- lut_in_bank0_replicate_0  output  DATA_W  write data, replicate 0.
- page_write_addr_replicate_0  output  ADDR_W  write address, replicate 0.
- lut_in_bank0_replicate_1  output  DATA_W  write data, replicate 1; always equals replicate 0.
- page_write_addr_replicate_1  output  ADDR_W  write address, replicate 1; always equals replicate 0.
- we  output  1  LUT write enable.
- busy  output  1  load in progress, including the final write cycle.
- load_done  output  1  one-cycle pulse after the last entry is written.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; we=0, in_ready=0, busy=0, load_done=0. Write data and address outputs are 0, and the internal address and remaining-count registers are 0.
- States:
  - IDLE -> LOAD on load_start. Capture addr<=load_base and rem<=(load_len==0 ? DEPTH : load_len). busy rises the next cycle.
  - LOAD: in_ready=1. A beat is accepted on in_valid&in_ready.
    - Per beat: addr<=addr+1 mod DEPTH (wraps 31->0) and rem<=rem-1.
    - The accepted beat that brings rem to 0 moves LOAD -> FLUSH.
  - FLUSH: in_ready=0. The last registered write is presented this cycle. At the end of the cycle, go to IDLE and assert load_done for exactly one cycle (the first IDLE cycle).
- Write timing: all write outputs are registered. A beat accepted in cycle N produces we=1 in cycle N+1, with data=in_data(N) and addr=write address at N on both replicates. we=0 in any cycle following a non-accepted cycle. Replicate outputs are driven from the same registers and are never unequal.
- Throughput: one entry per cycle. Back-to-back valid loads 32 entries in 32 accept cycles. The final we appears in the FLUSH cycle; load_done follows one cycle later.
- in_valid low during LOAD: stall. No write occurs and counters hold; there is no timeout.
- in_valid high outside LOAD: ignored, since in_ready=0.
- load_start while busy or in FLUSH: ignored, with no capture and no effect on the current load.
- load_start in the same cycle load_done is high: accepted, so a new load starts immediately.
- Rem counter is ADDR_W+1 bits so that 32 is representable.
- Reset mid-load: abort immediately. we drops asynchronously with reset and partial table contents are left as written. No load_done is generated.

Test Plan:
- Full load:
  - Stimulus: load_start with base=0, len=0; stream values i%8 for i=0..31 with in_valid held high.
  - Required: 32 consecutive we cycles, addresses 0..31, data i%8 on both replicates. busy high for 33 cycles. load_done pulses one cycle after the last we.
- Wrap-around:
  - Stimulus: base=30, len=4, data 5,6,7,1.
  - Required: writes to addresses 30,31,0,1 with those data. No write to address 2.
- Stalls:
  - Stimulus: len=3 with in_valid toggling 1,0,0,1,0,1.
  - Required: exactly 3 we pulses, each one cycle after an accepted beat. Addresses increment only on accept.
- Ignored start:
  - Stimulus: load_start with base=7 issued mid-load.
  - Required: the original addresses continue uninterrupted and no recapture occurs.
  - Stimulus: load_start coincident with load_done.
  - Required: a second load begins. in_ready rises on the next cycle.
- Reset mid-load:
  - Stimulus: rstn low after 10 of 32 beats.
  - Required: we=0 and busy=0 immediately, no load_done. After release, a new load with base=0, len=1 writes a single entry at address 0.
- Replicate coherence:
  - Stimulus: any random load.
  - Required: a checker asserts replicate 0 and replicate 1 data and addresses are equal on every cycle with we=1.
